// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, iteration count and the small sign/magnitude helpers.
package mdu_pkg;

  localparam int MDU_XLEN  = 32;
  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // MULT and DIV (bit 0 clear) treat their operands as two's complement.
  function automatic logic is_signed_op(mdu_op_t op);
    return ~op[0];
  endfunction

  function automatic logic [MDU_XLEN-1:0] neg32(logic [MDU_XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*MDU_XLEN-1:0] neg64(logic [2*MDU_XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [MDU_XLEN-1:0] magnitude(logic [MDU_XLEN-1:0] v, logic sgn_op);
    return (sgn_op && v[MDU_XLEN-1]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand, HI/LO write and result signals between the control/register-file
// side (master) and the multiply/divide unit (slave).
interface mult_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_XLEN
);
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: 32 shift-add or restoring
// divide steps on operand magnitudes, then a sign fix-up cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);

  state_e             state, state_nxt;
  mdu_op_t            op_q;
  logic [WIDTH-1:0]   a_orig, a_mag, b_mag;
  logic               res_neg, rem_neg;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo;
  logic               done_q, busy;
  logic               is_div, sgn_op;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  assign is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign sgn_op = is_signed_op(bus.op);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every comb output first prevents latch inference.
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == 5'(MDU_ITERS - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state != IDLE);
  end

  // One iteration: multiply adds into the upper half and shifts right; divide
  // shifts the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_mag[0] ? {1'b0, a_mag} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], a_mag[5'd31 - cnt]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (!is_div)
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up; divide by zero reports the dividend and an all-ones quotient.
  always_comb begin
    prod   = res_neg ? neg64(acc) : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_mag == '0) begin
        res_hi = a_orig;
        res_lo = '1;
      end else begin
        res_hi = rem_neg ? neg32(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        res_lo = res_neg ? neg32(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MDU_MULT;
      a_orig  <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_orig  <= bus.rs_val;
            a_mag   <= magnitude(bus.rs_val, sgn_op);
            b_mag   <= magnitude(bus.rt_val, sgn_op);
            res_neg <= sgn_op & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            rem_neg <= sgn_op & bus.rs_val[WIDTH-1];
            acc     <= '0;
            cnt     <= '0;
          end
          if (bus.hi_we) hi_q <= bus.wd;
          if (bus.lo_we) lo_q <= bus.wd;
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (!is_div) b_mag <= b_mag >> 1;
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of hand-computed results
// plus sequences for MTHI/MTLO, ignored restart and mid-operation reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic launch(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the start edge; counts edges until done and busy samples.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic mt_write(input logic hi_sel, input logic [31:0] data);
    @(negedge clk);
    bus.hi_we = hi_sel;
    bus.lo_we = ~hi_sel;
    bus.wd    = data;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  initial begin
    int edges, busy_cnt, done_cnt, first_done;
    logic [31:0] cap_hi, cap_lo;

    bus.start  = 1'b0;
    bus.op     = MDU_MULT;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wd     = '0;

    vecs.push_back('{"multu_max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_m3x5",   MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"div_m7d2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_7d2",    MDU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3});
    vecs.push_back('{"div_by0",     MDU_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",     MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{"mult_minsq",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    vecs.push_back('{"divu_big",    MDU_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF});
    vecs.push_back('{"div_7dm2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{"divu_by0",    MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"div_neg_by0", MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF});
    vecs.push_back('{"multu_shift", MDU_MULTU, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780});
    vecs.push_back('{"mult_m1sq",   MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1});

    #23;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(edges, busy_cnt);
      check({vecs[i].name, "_latency"}, edges, 33);
      check({vecs[i].name, "_busy_width"}, busy_cnt, 33);
      check({vecs[i].name, "_hi"}, bus.hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, bus.lo, vecs[i].exp_lo);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_pulse"}, bus.done, 0);
    end

    // MTHI / MTLO in IDLE land on the next edge.
    mt_write(1'b1, 32'hDEAD_BEEF);
    check("mthi", bus.hi, 32'hDEAD_BEEF);
    mt_write(1'b0, 32'h0BAD_F00D);
    check("mtlo", bus.lo, 32'h0BAD_F00D);

    // MTLO while busy is ignored until the result lands.
    launch(MDU_DIVU, 32'd7, 32'd2);
    repeat (5) @(posedge clk);
    #1;
    bus.lo_we = 1'b1;
    bus.wd    = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    check("mtlo_busy_ignored", bus.lo, 32'h0BAD_F00D);
    wait_done(edges, busy_cnt);
    check("mtlo_busy_result_lo", bus.lo, 32'd3);
    check("mtlo_busy_result_hi", bus.hi, 32'd1);

    // Start together with MTHI: write visible until FIX overwrites it.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = MDU_MULTU;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    bus.hi_we  = 1'b1;
    bus.wd     = 32'h0000_CAFE;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("start_mthi_hi", bus.hi, 32'h0000_CAFE);
    wait_done(edges, busy_cnt);
    check("start_mthi_res_hi", bus.hi, 0);
    check("start_mthi_res_lo", bus.lo, 32'd6);

    // Second start mid-operation and operand changes after launch are ignored.
    launch(MDU_MULTU, 32'd2, 32'd3);
    bus.op     = MDU_DIV;
    bus.rs_val = 32'd99;
    done_cnt   = 0;
    first_done = 0;
    cap_hi     = '0;
    cap_lo     = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) begin
        bus.start  = 1'b1;
        bus.op     = MDU_DIVU;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
      end
      if (i == 10) bus.start = 1'b0;
      if (bus.done) begin
        if (done_cnt == 0) begin
          first_done = i;
          cap_hi     = bus.hi;
          cap_lo     = bus.lo;
        end
        done_cnt++;
      end
    end
    check("restart_done_count", done_cnt, 1);
    check("restart_latency", first_done, 33);
    check("restart_hi", cap_hi, 0);
    check("restart_lo", cap_lo, 32'd6);
    check("restart_idle", bus.busy, 0);

    // Asynchronous reset mid-operation discards everything.
    mt_write(1'b1, 32'h1111_1111);
    mt_write(1'b0, 32'h2222_2222);
    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (15) @(posedge clk);
    #2;
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b0;
    launch(MDU_DIVU, 32'd100, 32'd7);
    wait_done(edges, busy_cnt);
    check("post_rst_latency", edges, 33);
    check("post_rst_lo", bus.lo, 32'd14);
    check("post_rst_hi", bus.hi, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
